// File: rtl/branch_pkg.sv
// Shared definitions for the branch predictor: branch funct3 codes,
// the 2-bit counter state type and its saturating update rule.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_t;

  // Counters stick at SNT/ST rather than wrapping around.
  function automatic bht_state_t sat_update(input bht_state_t state, input logic taken);
    bht_state_t next_state;
    next_state = state;
    if (taken) begin
      if (state != ST) next_state = bht_state_t'(state + 2'd1);
    end else begin
      if (state != SNT) next_state = bht_state_t'(state - 2'd1);
    end
    return next_state;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Decode/execute-side signal bundle of the branch predictor; the pipeline
// drives it as master and the predictor sits on the slave side.
interface branch_predict_unit_if #(
  parameter int XLEN    = 32,
  parameter int COUNT_W = 32
);

  logic               d_valid;
  logic               d_is_branch;
  logic [XLEN-1:0]    d_pc;
  logic               d_predict_taken;

  logic               e_valid;
  logic               e_is_branch;
  logic [XLEN-1:0]    e_pc;
  logic [2:0]         e_funct3;
  logic               e_zero;
  logic               e_lt;
  logic               e_ltu;
  logic               e_predicted_taken;
  logic               e_taken;
  logic               e_mispredict;
  logic               e_illegal;

  logic [COUNT_W-1:0] branch_count;
  logic [COUNT_W-1:0] mispredict_count;

  modport master (
    output d_valid, d_is_branch, d_pc,
    output e_valid, e_is_branch, e_pc, e_funct3, e_zero, e_lt, e_ltu, e_predicted_taken,
    input  d_predict_taken, e_taken, e_mispredict, e_illegal,
    input  branch_count, mispredict_count
  );

  modport slave (
    input  d_valid, d_is_branch, d_pc,
    input  e_valid, e_is_branch, e_pc, e_funct3, e_zero, e_lt, e_ltu, e_predicted_taken,
    output d_predict_taken, e_taken, e_mispredict, e_illegal,
    output branch_count, mispredict_count
  );

endinterface

// File: rtl/branch_condition_eval.sv
// Decodes branch funct3 against the ALU flags into a taken bit; the
// reserved encodings 010/011 report illegal and never resolve as taken.
module branch_condition_eval
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = !zero;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = !lt;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = !ltu;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution plus a direct-mapped table of 2-bit saturating counters
// that predicts decode-stage branches, with saturating statistics counters.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int         XLEN       = 32,
  parameter int         INDEX_BITS = 6,
  parameter int         COUNT_W    = 32,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_predict_unit_if.slave  bus
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  bht_state_t             bht_q [ENTRIES];
  logic [COUNT_W-1:0]     branch_q;
  logic [COUNT_W-1:0]     mispredict_q;

  logic [INDEX_BITS-1:0]  d_idx;
  logic [INDEX_BITS-1:0]  e_idx;
  bht_state_t             d_entry;
  logic                   res;
  logic                   cond_taken;
  logic                   cond_illegal;
  logic                   update;
  logic                   mispredict;

  branch_condition_eval u_cond (
    .funct3  (bus.e_funct3),
    .zero    (bus.e_zero),
    .lt      (bus.e_lt),
    .ltu     (bus.e_ltu),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  assign d_idx   = bus.d_pc[INDEX_BITS+1:2];
  assign e_idx   = bus.e_pc[INDEX_BITS+1:2];
  assign d_entry = bht_q[d_idx];

  assign res        = bus.e_valid & bus.e_is_branch;
  assign update     = res & !cond_illegal;
  assign mispredict = update & (cond_taken != bus.e_predicted_taken);

  // Decode reads the table directly, so a same-cycle update is seen only next cycle.
  assign bus.d_predict_taken  = bus.d_valid & bus.d_is_branch & d_entry[1];
  assign bus.e_taken          = res & cond_taken;
  assign bus.e_illegal        = res & cond_illegal;
  assign bus.e_mispredict     = mispredict;
  assign bus.branch_count     = branch_q;
  assign bus.mispredict_count = mispredict_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= bht_state_t'(INIT_STATE);
      branch_q     <= '0;
      mispredict_q <= '0;
    end else if (update) begin
      bht_q[e_idx] <= sat_update(bht_q[e_idx], cond_taken);
      if (branch_q != '1) branch_q <= branch_q + COUNT_W'(1);
      if (mispredict && (mispredict_q != '1)) mispredict_q <= mispredict_q + COUNT_W'(1);
    end
  end

endmodule
